// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared widths and lock-state type for the switch arbiter
// Purpose: default address/data widths and the per-output packet lock state.
package common_pkg;

    localparam int DEFAULT_A_W = 8;
    localparam int DEFAULT_D_W = 16;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/mux.sv
// rtl/mux.sv - N-way word selector
// Purpose: pick one of N input words by binary index.
// Ports: i_data (N words of W bits), i_sel (index), o_data (selected word).
module mux #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0][W-1:0] i_data,
    input  logic [IW-1:0]       i_sel,
    output logic [W-1:0]        o_data
);

    assign o_data = i_data[i_sel];

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin requester selection from a priority pointer
// Purpose: grant the first active request found scanning upward from ptr,
//          wrapping N-1 -> 0.
// Ports: req (request vector), ptr (highest-priority index),
//        grant (one-hot, zero when no request), grant_idx (binary winner).
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          w_found;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k folded back into 0..N-1 (ptr is always < N)
            w_sum = {1'b0, ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found         = 1'b1;
                grant[w_idx]    = 1'b1;
                grant_idx       = w_idx;
            end
        end
    end

endmodule

// File: rtl/t_switch_arb.sv
// rtl/t_switch_arb.sv - N_IN x N_OUT flit switch with per-output round-robin
// Purpose: route input flits to a registered output by in_dst, one flit per
//          output per cycle; out-of-range destinations are dropped and counted.
// Option:  define T_SWITCH_PKT_LOCK_EN to hold an output on one input until
//          that input's last flit (flit bit FLIT_W-1) is accepted.
// Ports:   clk, rst (async active-high); in_valid/in_ready/in_flit/in_dst per
//          input; out_valid/out_ready/out_flit per output; drop_cnt (saturating).
module t_switch_arb
    import common_pkg::*;
#(
    parameter  int N_IN   = 4,
    parameter  int N_OUT  = 3,
    parameter  int A_W    = DEFAULT_A_W,
    parameter  int D_W    = DEFAULT_D_W,
    localparam int FLIT_W = A_W + D_W + 1,
    localparam int DST_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_IN-1:0]               in_valid,
    output logic [N_IN-1:0]               in_ready,
    input  logic [N_IN-1:0][FLIT_W-1:0]   in_flit,
    input  logic [N_IN-1:0][DST_W-1:0]    in_dst,
    output logic [N_OUT-1:0]              out_valid,
    input  logic [N_OUT-1:0]              out_ready,
    output logic [N_OUT-1:0][FLIT_W-1:0]  out_flit,
    output logic [15:0]                   drop_cnt
);

    logic [N_OUT-1:0][N_IN-1:0]   w_req;
    logic [N_OUT-1:0][N_IN-1:0]   w_grant;
    logic [N_OUT-1:0][IW-1:0]     w_gidx;
    logic [N_OUT-1:0][FLIT_W-1:0] w_sel_flit;
    logic [N_OUT-1:0]             w_free;
    logic [N_OUT-1:0]             w_acc;
    logic [N_IN-1:0]              w_drop;
    logic [N_IN-1:0]              w_rdy;
    logic [16:0]                  w_drop_sum;
    logic [N_OUT-1:0][IW-1:0]     r_ptr;

`ifdef T_SWITCH_PKT_LOCK_EN
    lock_state_t                  r_lock  [N_OUT];
    logic [IW-1:0]                r_owner [N_OUT];
`endif

    always_comb begin
        w_req = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                w_req[o][i] = in_valid[i] && (in_dst[i] == DST_W'(o));
`ifdef T_SWITCH_PKT_LOCK_EN
                // a locked output only listens to the input that owns it
                if (r_lock[o] == LOCK_LOCKED && r_owner[o] != IW'(i)) begin
                    w_req[o][i] = 1'b0;
                end
`endif
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_out
            rr_arbiter #(.N(N_IN)) u_arb (
                .req       (w_req[g]),
                .ptr       (r_ptr[g]),
                .grant     (w_grant[g]),
                .grant_idx (w_gidx[g])
            );
            mux #(.N(N_IN), .W(FLIT_W)) u_mux (
                .i_data (in_flit),
                .i_sel  (w_gidx[g]),
                .o_data (w_sel_flit[g])
            );
            assign w_free[g] = !out_valid[g] || out_ready[g];
            assign w_acc[g]  = (|w_grant[g]) && w_free[g];
        end
    endgenerate

    always_comb begin
        w_drop     = '0;
        w_drop_sum = {1'b0, drop_cnt};
        for (int i = 0; i < N_IN; i++) begin
            w_drop[i] = in_valid[i] && (32'(in_dst[i]) >= N_OUT);
            if (w_drop[i]) begin
                w_drop_sum = w_drop_sum + 17'd1;
            end
        end
        w_rdy = w_drop;
        for (int o = 0; o < N_OUT; o++) begin
            if (w_free[o]) begin
                w_rdy = w_rdy | w_grant[o];
            end
        end
    end

    assign in_ready = rst ? '0 : w_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_flit  <= '0;
            r_ptr     <= '0;
            drop_cnt  <= '0;
`ifdef T_SWITCH_PKT_LOCK_EN
            for (int o = 0; o < N_OUT; o++) begin
                r_lock[o]  <= LOCK_IDLE;
                r_owner[o] <= '0;
            end
`endif
        end else begin
            drop_cnt <= (w_drop_sum > 17'h0FFFF) ? 16'hFFFF : w_drop_sum[15:0];
            for (int o = 0; o < N_OUT; o++) begin
                if (w_acc[o]) begin
                    out_valid[o] <= 1'b1;
                    out_flit[o]  <= w_sel_flit[o];
                    r_ptr[o]     <= (w_gidx[o] == IW'(N_IN - 1)) ? '0 : w_gidx[o] + 1'b1;
`ifdef T_SWITCH_PKT_LOCK_EN
                    case (r_lock[o])
                        LOCK_IDLE: begin
                            if (!w_sel_flit[o][FLIT_W-1]) begin
                                r_lock[o]  <= LOCK_LOCKED;
                                r_owner[o] <= w_gidx[o];
                            end
                        end
                        LOCK_LOCKED: begin
                            if (w_sel_flit[o][FLIT_W-1]) begin
                                r_lock[o] <= LOCK_IDLE;
                            end
                        end
                        default: r_lock[o] <= LOCK_IDLE;
                    endcase
`endif
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_t_switch_arb.sv
// tb/tb_t_switch_arb.sv - randomized and directed checks of t_switch_arb against a reference model
module tb_t_switch_arb;
    import common_pkg::*;

    localparam int NI = 4;
    localparam int NO = 3;
    localparam int FW = DEFAULT_A_W + DEFAULT_D_W + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NI-1:0]          in_valid;
    logic [NI-1:0]          in_ready;
    logic [NI-1:0][FW-1:0]  in_flit;
    logic [NI-1:0][1:0]     in_dst;
    logic [NO-1:0]          out_valid;
    logic [NO-1:0]          out_ready;
    logic [NO-1:0][FW-1:0]  out_flit;
    logic [15:0]            drop_cnt;

    t_switch_arb dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flit   (in_flit),
        .in_dst    (in_dst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: queue-free, state kept as plain ints per output
    int            m_ptr   [NO];
    logic          m_ov    [NO];
    logic [FW-1:0] m_of    [NO];
    logic [FW-1:0] m_nf    [NO];
    int            m_owner [NO];
    int            m_acc   [NO];
    int            m_drop;
    int            m_ndrop;
    logic [NI-1:0] exp_rdy;
    logic [NI-1:0] s_rdy;

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            m_ptr[o] = 0; m_ov[o] = 1'b0; m_of[o] = '0; m_owner[o] = -1; m_acc[o] = -1;
        end
        m_drop = 0;
    endtask

    task automatic model_comb();
        bit found;
        int i;
        exp_rdy = '0;
        m_ndrop = 0;
        for (int o = 0; o < NO; o++) begin
            m_acc[o] = -1;
            found = 0;
            for (int k = 0; k < NI; k++) begin
                i = (m_ptr[o] + k) % NI;
                if (!found && in_valid[i] && int'(in_dst[i]) == o &&
                    (m_owner[o] < 0 || m_owner[o] == i)) begin
                    found = 1;
                    if (!m_ov[o] || out_ready[o]) begin
                        m_acc[o] = i;
                        m_nf[o]  = in_flit[i];
                        exp_rdy[i] = 1'b1;
                    end
                end
            end
        end
        for (int j = 0; j < NI; j++) begin
            if (in_valid[j] && int'(in_dst[j]) >= NO) begin
                exp_rdy[j] = 1'b1;
                m_ndrop++;
            end
        end
    endtask

    task automatic model_seq();
        for (int o = 0; o < NO; o++) begin
            if (m_acc[o] >= 0) begin
                m_ov[o]  = 1'b1;
                m_of[o]  = m_nf[o];
                m_ptr[o] = (m_acc[o] + 1) % NI;
`ifdef T_SWITCH_PKT_LOCK_EN
                if (m_owner[o] < 0 && !m_nf[o][FW-1]) m_owner[o] = m_acc[o];
                else if (m_owner[o] >= 0 && m_nf[o][FW-1]) m_owner[o] = -1;
`endif
            end else if (out_ready[o]) begin
                m_ov[o] = 1'b0;
            end
        end
        m_drop = (m_drop + m_ndrop > 65535) ? 65535 : m_drop + m_ndrop;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_comb();
        s_rdy = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        model_seq();
        #1;
        for (int o = 0; o < NO; o++) begin
            chk("out_valid", 32'(out_valid[o]), 32'(m_ov[o]));
            if (m_ov[o]) chk("out_flit", 32'(out_flit[o]), 32'(m_of[o]));
        end
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic hit_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        for (int o = 0; o < NO; o++) chk("rst_out_flit", 32'(out_flit[o]), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [FW-1:0] f1, f2;

    initial begin
        rst = 1'b0; in_valid = '0; in_flit = '0; in_dst = '0; out_ready = '1;
        hit_reset();

        // contention: all inputs to output 1
        for (int i = 0; i < NI; i++) begin
            in_flit[i] = FW'($urandom); in_dst[i] = 2'd1;
        end
        in_valid = '1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("cont_grant", 32'(s_rdy), 32'(1) << (k % NI));
            chk("cont_flit", 32'(out_flit[1]), 32'(in_flit[k % NI]));
        end

        // backpressure on output 2 from input 1
        in_valid = '0;
        cycle();
        f1 = FW'($urandom); f2 = f1 ^ FW'(1);
        in_valid = 4'b0010; in_dst[1] = 2'd2; in_flit[1] = f1; out_ready = 3'b011;
        cycle();
        chk("bp_first", 32'(s_rdy), 32'b0010);
        in_flit[1] = f2;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_stall_rdy", 32'(s_rdy[1]), 32'd0);
            chk("bp_hold", 32'(out_flit[2]), 32'(f1));
        end
        out_ready = 3'b111;
        cycle();
        chk("bp_release_rdy", 32'(s_rdy[1]), 32'd1);
        chk("bp_next", 32'(out_flit[2]), 32'(f2));
        in_valid = '0;
        cycle();
        chk("bp_drain", 32'(out_valid[2]), 32'd0);

        // parallel: i -> i for three outputs
        in_valid = 4'b0111; in_dst[0] = 2'd0; in_dst[1] = 2'd1; in_dst[2] = 2'd2;
        cycle();
        chk("par_rdy", 32'(s_rdy), 32'b0111);
        chk("par_valid", 32'(out_valid), 32'b111);
        in_valid = '0;
        cycle();

        // drop: input 3 to nonexistent output 3
        hit_reset();
        in_valid = 4'b1000; in_dst[3] = 2'd3;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("drop_rdy", 32'(s_rdy), 32'b1000);
            chk("drop_quiet", 32'(out_valid), 32'd0);
        end
        chk("drop_cnt3", 32'(drop_cnt), 32'd3);
        in_valid = '0;

`ifdef T_SWITCH_PKT_LOCK_EN
        // lock: 3-flit packet from input 0 holds output 0 against input 1
        hit_reset();
        in_dst[0] = 2'd0; in_dst[1] = 2'd0; in_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            in_flit[0] = FW'($urandom);
            in_flit[0][FW-1] = (k == 2);
            cycle();
            chk("lock_hold", 32'(s_rdy), 32'b0001);
        end
        in_valid = 4'b0010;
        cycle();
        chk("lock_release", 32'(s_rdy), 32'b0010);
        in_valid = '0;
`endif

        // randomized traffic with one reset in the middle
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NI; i++) begin
                in_valid[i] = ($urandom_range(0, 3) != 0);
                in_dst[i]   = 2'($urandom_range(0, 3));
                in_flit[i]  = FW'($urandom);
            end
            for (int o = 0; o < NO; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
            if (n == 1500) begin
                hit_reset();
                in_valid = '1;
                for (int i = 0; i < NI; i++) in_dst[i] = 2'd0;
                cycle();
                chk("post_rst_grant", 32'(s_rdy), 32'b0001);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
